// File: rtl/dottori_scandoubler_pkg.sv
// Shared constants and types for the dottori scandoubler: buffer word layout,
// pass FSM encodings and the registered video bundle.
package dottori_scandoubler_pkg;

  localparam int unsigned AW_DEF           = 8;
  localparam int unsigned BW_DEF           = 4;
  localparam int unsigned DOTTORI_LINE_LEN = 256;

  localparam int unsigned BF_R  = 0;
  localparam int unsigned BF_G  = 1;
  localparam int unsigned BF_B  = 2;
  localparam int unsigned BF_HB = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS0 = 2'd1;
  localparam logic [1:0] ST_PASS1 = 2'd2;

  typedef struct packed {
    logic ce;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic b;
    logic g;
    logic r;
  } vid_t;

  // Colour is forced dark whenever either blanking flag is set.
  function automatic vid_t blank_vid(input vid_t v);
    vid_t o;
    o = v;
    if (v.hb || v.vb) begin
      o.r = 1'b0;
      o.g = 1'b0;
      o.b = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/dottori_linebuf.sv
// Ping-pong line store: simple dual-port RAM holding two lines, registered read.
module dottori_linebuf #(
  parameter int unsigned AW = 8,
  parameter int unsigned BW = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [BW-1:0] wdata_i,
  input  logic [AW:0]   raddr_i,
  output logic [BW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** (AW + 1);

  logic [BW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dottori_scandoubler.sv
// Line doubler behind the dottori video core: captures each 15 kHz line into a
// ping-pong buffer and replays the previous line twice at the 8 MHz clock.
module dottori_scandoubler
  import dottori_scandoubler_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned BW = BW_DEF
) (
  input  logic CLK_8M,
  input  logic nRESET,
  input  logic CE_PIX,
  input  logic RED_IN,
  input  logic GREEN_IN,
  input  logic BLUE_IN,
  input  logic H_SYNC_IN,
  input  logic V_SYNC_IN,
  input  logic H_BLANK_IN,
  input  logic V_BLANK_IN,
  input  logic SD_EN,
  output logic RED,
  output logic GREEN,
  output logic BLUE,
  output logic H_SYNC,
  output logic V_SYNC,
  output logic H_BLANK,
  output logic V_BLANK,
  output logic CE_PIX_OUT
);

  localparam logic [AW-1:0] X_MAX = '1;

  logic          wsel_q, wsel_d;
  logic [AW-1:0] wx_q, wx_d;
  logic          seen_q, seen_d;
  logic          hs_prev_q, hs_prev_d;
  logic [AW-1:0] hs_cnt_q, hs_cnt_d;
  logic [AW-1:0] line_len_q, line_len_d;
  logic [AW-1:0] hs_len_q, hs_len_d;
  logic          vs_l_q, vs_l_d;
  logic          vb_l_q, vb_l_d;
  logic          mode_q, mode_d;
  logic          out_active_q, out_active_d;
  logic          line_edge_c;
  logic [AW:0]   wr_addr_c;
  logic [AW:0]   rd_addr_c;
  logic [BW-1:0] wr_data_c;
  logic [BW-1:0] rd_word_c;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rx_q, rx_d;
  logic          last_c;

  vid_t          in_c;
  vid_t          pt_q;
  vid_t          dbl_c;
  vid_t          out_q, out_d;

  assign line_edge_c = CE_PIX && H_SYNC_IN && !hs_prev_q;
  assign wr_data_c   = BW'({H_BLANK_IN, BLUE_IN, GREEN_IN, RED_IN});

  // Input capture: the edge pixel opens the new buffer at entry 0.
  always_comb begin
    wsel_d       = wsel_q;
    wx_d         = wx_q;
    seen_d       = seen_q;
    hs_prev_d    = hs_prev_q;
    hs_cnt_d     = hs_cnt_q;
    line_len_d   = line_len_q;
    hs_len_d     = hs_len_q;
    vs_l_d       = vs_l_q;
    vb_l_d       = vb_l_q;
    mode_d       = mode_q;
    out_active_d = out_active_q;
    wr_addr_c    = {wsel_q, wx_q};
    if (CE_PIX) begin
      hs_prev_d = H_SYNC_IN;
      if (line_edge_c) begin
        wsel_d       = ~wsel_q;
        wx_d         = AW'(1);
        seen_d       = 1'b1;
        line_len_d   = wx_q;
        hs_len_d     = hs_cnt_q;
        hs_cnt_d     = AW'(1);
        vs_l_d       = V_SYNC_IN;
        vb_l_d       = V_BLANK_IN;
        mode_d       = SD_EN;
        out_active_d = (wx_q != '0);
        wr_addr_c    = {~wsel_q, AW'(0)};
      end else begin
        // Before the first edge the partial line is never counted.
        if (seen_q && (wx_q != X_MAX)) begin
          wx_d = wx_q + AW'(1);
        end
        if (H_SYNC_IN && (hs_cnt_q != X_MAX)) begin
          hs_cnt_d = hs_cnt_q + AW'(1);
        end
      end
    end
  end

  // Replay FSM: two passes over the finished line; any edge restarts pass 0.
  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    last_c  = (rx_q == (line_len_q - AW'(1)));
    if (line_edge_c) begin
      rx_d    = '0;
      state_d = (wx_q != '0) ? ST_PASS0 : ST_IDLE;
    end else begin
      case (state_q)
        ST_PASS0: begin
          if (last_c) begin
            state_d = ST_PASS1;
            rx_d    = '0;
          end else begin
            rx_d = rx_q + AW'(1);
          end
        end
        ST_PASS1: begin
          if (last_c) begin
            state_d = ST_IDLE;
            rx_d    = '0;
          end else begin
            rx_d = rx_q + AW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          rx_d    = '0;
        end
      endcase
    end
  end

  // Read ahead on next-state values so pixel 0 leaves two clocks after the edge.
  assign rd_addr_c = {~wsel_d, rx_d};

  dottori_linebuf #(
    .AW (AW),
    .BW (BW)
  ) u_linebuf (
    .clk_i   (CLK_8M),
    .we_i    (CE_PIX),
    .waddr_i (wr_addr_c),
    .wdata_i (wr_data_c),
    .raddr_i (rd_addr_c),
    .rdata_o (rd_word_c)
  );

  always_comb begin
    in_c    = '0;
    in_c.ce = CE_PIX;
    in_c.hs = H_SYNC_IN;
    in_c.vs = V_SYNC_IN;
    in_c.hb = H_BLANK_IN;
    in_c.vb = V_BLANK_IN;
    in_c.b  = BLUE_IN;
    in_c.g  = GREEN_IN;
    in_c.r  = RED_IN;
  end

  // Doubled stream assembly; idle or inactive time is shown as blank.
  always_comb begin
    dbl_c    = '0;
    dbl_c.ce = 1'b1;
    dbl_c.vs = vs_l_q;
    dbl_c.vb = vb_l_q;
    dbl_c.hb = 1'b1;
    if (out_active_q && (state_q != ST_IDLE)) begin
      dbl_c.hs = (rx_q < hs_len_q);
      dbl_c.hb = rd_word_c[BF_HB];
      dbl_c.b  = rd_word_c[BF_B];
      dbl_c.g  = rd_word_c[BF_G];
      dbl_c.r  = rd_word_c[BF_R];
    end
    out_d = blank_vid(mode_q ? dbl_c : pt_q);
  end

  always_ff @(posedge CLK_8M) begin
    if (!nRESET) begin
      wsel_q       <= 1'b0;
      wx_q         <= '0;
      seen_q       <= 1'b0;
      hs_prev_q    <= 1'b0;
      hs_cnt_q     <= '0;
      line_len_q   <= '0;
      hs_len_q     <= '0;
      vs_l_q       <= 1'b0;
      vb_l_q       <= 1'b0;
      mode_q       <= 1'b0;
      out_active_q <= 1'b0;
      state_q      <= ST_IDLE;
      rx_q         <= '0;
      pt_q         <= '0;
      out_q        <= '0;
    end else begin
      wsel_q       <= wsel_d;
      wx_q         <= wx_d;
      seen_q       <= seen_d;
      hs_prev_q    <= hs_prev_d;
      hs_cnt_q     <= hs_cnt_d;
      line_len_q   <= line_len_d;
      hs_len_q     <= hs_len_d;
      vs_l_q       <= vs_l_d;
      vb_l_q       <= vb_l_d;
      mode_q       <= mode_d;
      out_active_q <= out_active_d;
      state_q      <= state_d;
      rx_q         <= rx_d;
      pt_q         <= in_c;
      out_q        <= out_d;
    end
  end

  assign RED        = out_q.r;
  assign GREEN      = out_q.g;
  assign BLUE       = out_q.b;
  assign H_SYNC     = out_q.hs;
  assign V_SYNC     = out_q.vs;
  assign H_BLANK    = out_q.hb;
  assign V_BLANK    = out_q.vb;
  assign CE_PIX_OUT = out_q.ce;

endmodule

// File: tb/tb_dottori_scandoubler.sv
// Scoreboard bench: a line-level model pushes the expected output for two clocks
// ahead; a monitor pops and compares the whole output vector every clock.
module tb_dottori_scandoubler;
  import dottori_scandoubler_pkg::*;

  localparam int LMAX = DOTTORI_LINE_LEN;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic ce = 1'b0;
  logic r_in = 1'b0, g_in = 1'b0, b_in = 1'b0;
  logic hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0, sd_in = 1'b0;
  logic r_o, g_o, b_o, hs_o, vs_o, hb_o, vb_o, ce_o;

  always #5 clk = ~clk;

  dottori_scandoubler dut (
    .CLK_8M     (clk),
    .nRESET     (nrst),
    .CE_PIX     (ce),
    .RED_IN     (r_in),
    .GREEN_IN   (g_in),
    .BLUE_IN    (b_in),
    .H_SYNC_IN  (hs_in),
    .V_SYNC_IN  (vs_in),
    .H_BLANK_IN (hb_in),
    .V_BLANK_IN (vb_in),
    .SD_EN      (sd_in),
    .RED        (r_o),
    .GREEN      (g_o),
    .BLUE       (b_o),
    .H_SYNC     (hs_o),
    .V_SYNC     (vs_o),
    .H_BLANK    (hb_o),
    .V_BLANK    (vb_o),
    .CE_PIX_OUT (ce_o)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  v;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line-level reference state
  logic [3:0] cur_buf [LMAX];
  logic [3:0] prev_buf [LMAX];
  int         cur_cnt = 0, hs_run = 0, m_len = 0, m_hslen = 0, edge_cyc = 0;
  bit         have_edge = 1'b0, hs_prev = 1'b0, m_mode = 1'b0, m_vs = 1'b0, m_vb = 1'b0;

  task automatic step(input logic ce_i, input logic [2:0] rgb_i, input logic hs_i,
                      input logic vs_i, input logic hb_i, input logic vb_i,
                      input logic sd_i, input logic rstn_i);
    logic [7:0] e;
    logic [3:0] w;
    logic [3:0] pix;
    exp_t       it;
    int         k, p;
    @(negedge clk);
    nrst = rstn_i; ce = ce_i; b_in = rgb_i[2]; g_in = rgb_i[1]; r_in = rgb_i[0];
    hs_in = hs_i; vs_in = vs_i; hb_in = hb_i; vb_in = vb_i; sd_in = sd_i;
    if (!rstn_i) begin
      have_edge = 1'b0; hs_prev = 1'b0; cur_cnt = 0; hs_run = 0;
      m_mode = 1'b0; m_len = 0; m_hslen = 0; m_vs = 1'b0; m_vb = 1'b0;
      if (sbq.size() > 0 && sbq[sbq.size()-1].cyc == cyc + 1) begin
        it = sbq.pop_back();
        it.v = '0;
        sbq.push_back(it);
      end
      it.cyc = cyc + 2;
      it.v = '0;
      sbq.push_back(it);
      return;
    end
    pix = {hb_i, rgb_i};
    if (ce_i) begin
      if (hs_i && !hs_prev) begin
        prev_buf = cur_buf;
        m_len = (cur_cnt > 255) ? 255 : cur_cnt;
        m_hslen = hs_run;
        hs_run = 1; cur_cnt = 1; cur_buf[0] = pix;
        m_vs = vs_i; m_vb = vb_i; m_mode = sd_i;
        edge_cyc = int'(cyc); have_edge = 1'b1;
      end else begin
        if (have_edge) begin
          cur_buf[(cur_cnt > 255) ? 255 : cur_cnt] = pix;
          if (cur_cnt < 256) cur_cnt++;
        end
        if (hs_i && hs_run < 255) hs_run++;
      end
      hs_prev = hs_i;
    end
    if (!m_mode) begin
      e = {ce_i, hs_i, vs_i, hb_i, vb_i, (hb_i || vb_i) ? 3'b000 : rgb_i};
    end else begin
      k = int'(cyc) - edge_cyc;
      if (m_len != 0 && k < 2 * m_len) begin
        p = (k < m_len) ? k : k - m_len;
        w = prev_buf[p];
        e = {1'b1, (p < m_hslen), m_vs, w[3], m_vb, (w[3] || m_vb) ? 3'b000 : w[2:0]};
      end else begin
        e = {1'b1, 1'b0, m_vs, 1'b1, m_vb, 3'b000};
      end
    end
    it.cyc = cyc + 2;
    it.v = e;
    sbq.push_back(it);
  endtask

  // One input line: npix pixel periods of two clocks, hsync at the start.
  task automatic drive_line(input int npix, input int seed, input logic vs_i, input logic vb_i,
                            input int sd_at, input logic sd0, input logic sd1, input int rst_at);
    for (int k = 0; k < npix; k++) begin
      for (int h = 0; h < 2; h++) begin
        step(h == 0, 3'(k + seed), k < 24, vs_i, k < 32, vb_i,
             (k >= sd_at) ? sd1 : sd0, (2 * k + h) != rst_at);
      end
    end
  endtask

  exp_t mon_e;
  logic [7:0] got;
  always @(negedge clk) begin
    got = {ce_o, hs_o, vs_o, hb_o, vb_o, b_o, g_o, r_o};
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      total++;
      if (mon_e.cyc != cyc || got !== mon_e.v) begin
        bad++;
        $display("FAIL vid cyc=%0d got=%b exp=%b", mon_e.cyc, got, mon_e.v);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_line(256, 1, 1'b1, 1'b1, 999, 1'b0, 1'b0, -1); // pass-through, vertical blank
    drive_line(256, 2, 1'b0, 1'b0, 128, 1'b0, 1'b1, -1); // SD_EN rises mid-line
    drive_line(256, 0, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1); // first doubled line
    drive_line(256, 0, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1); // ramp replayed
    drive_line(100, 3, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1); // short line
    drive_line(256, 4, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1);
    drive_line(256, 5, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1);
    drive_line(200, 6, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1); // early edge aborts pass 1
    drive_line(300, 7, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1); // overlong line
    drive_line(256, 0, 1'b1, 1'b1, 999, 1'b1, 1'b1, -1);
    drive_line(256, 3, 1'b0, 1'b0, 999, 1'b1, 1'b1, 100); // reset mid-pass
    drive_line(256, 1, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1);  // first edge after reset: idle
    drive_line(256, 2, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1);
    drive_line(64, 3, 1'b0, 1'b0, 999, 1'b1, 1'b1, -1);
    drive_line(256, 5, 1'b0, 1'b0, 999, 1'b0, 1'b0, -1);  // back to pass-through
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8 && sbq.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d need=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
